// File: rtl/mem_req_arbiter.sv
// Shares one sram-like memory port between instruction fetch (read-only) and
// the load/store path. One transaction is in flight at a time: it is granted,
// then the address is handed over, then the response comes back. Data requests
// win by default. A starvation counter makes sure instruction fetch still
// makes progress.
module mem_req_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  // instruction fetch master
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  // load/store master
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  // memory port
  output logic        mem_req,
  output logic        mem_wr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             grant_q, grant_d;        // 0 = inst, 1 = data
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic             granted_req;

  // Request line of whichever master currently holds the grant
  assign granted_req = grant_q ? data_req : inst_req;

  // Next-state logic: arbitration in IDLE, address handshake, response wait
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    starve_cnt_d = starve_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (inst_req || data_req) begin
          state_d = ST_ADDR;
          if (inst_req && data_req) begin
            grant_d = (starve_cnt_q == LIMIT) ? 1'b0 : 1'b1;
          end else begin
            grant_d = data_req;
          end
          // Count only data wins that left a fetch waiting
          if (grant_d && inst_req) begin
            starve_cnt_d = (starve_cnt_q == LIMIT) ? LIMIT
                                                   : starve_cnt_q + CNT_W'(1);
          end else begin
            starve_cnt_d = '0;
          end
        end
      end
      ST_ADDR: begin
        // A dropped request is a flush: nothing was issued, so just go back
        if (!granted_req) begin
          state_d = ST_IDLE;
        end else if (mem_addr_ok) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (mem_data_ok) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      grant_q      <= 1'b0;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // Output steering: memory fields only in ADDR, responses only in WAIT,
  // and everything held at zero while reset is asserted
  always_comb begin
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    inst_rdata   = '0;
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    data_rdata   = '0;
    mem_req      = 1'b0;
    mem_wr       = 1'b0;
    mem_wstrb    = '0;
    mem_addr     = '0;
    mem_wdata    = '0;
    if (!reset) begin
      case (state_q)
        ST_ADDR: begin
          mem_req = granted_req;
          if (grant_q) begin
            mem_wr       = data_wr;
            mem_wstrb    = data_wstrb;
            mem_addr     = data_addr;
            mem_wdata    = data_wdata;
            data_addr_ok = mem_addr_ok & granted_req;
          end else begin
            mem_addr     = inst_addr;
            inst_addr_ok = mem_addr_ok & granted_req;
          end
        end
        ST_WAIT: begin
          if (grant_q) begin
            data_data_ok = mem_data_ok;
            data_rdata   = mem_rdata;
          end else begin
            inst_data_ok = mem_data_ok;
            inst_rdata   = mem_rdata;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Bench for mem_req_arbiter: directed scenarios followed by randomized
// traffic. Every cycle is compared against a transaction-level reference
// model that tracks who owns the port and whether its address was taken.
module tb_mem_req_arbiter;

  localparam int unsigned LIMIT = 4;

  logic        clk;
  logic        reset;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req, mem_wr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;

  mem_req_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk          (clk),
    .reset        (reset),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_wstrb   (data_wstrb),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .mem_req      (mem_req),
    .mem_wr       (mem_wr),
    .mem_wstrb    (mem_wstrb),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_addr_ok  (mem_addr_ok),
    .mem_data_ok  (mem_data_ok),
    .mem_rdata    (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Single comparison point for the whole bench
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Reference model: owner -1 = port free, 0 = fetch, 1 = load/store
  int          m_owner     = -1;
  bit          m_addr_done = 1'b0;
  int unsigned m_streak    = 0;

  logic [69:0] e_mem;
  logic [33:0] e_inst, e_data;

  // Expected outputs for the current cycle from model state and live inputs
  function automatic void model_outputs();
    logic r;
    e_mem  = '0;
    e_inst = '0;
    e_data = '0;
    if (!reset && m_owner >= 0) begin
      if (!m_addr_done) begin
        if (m_owner == 1) begin
          r      = data_req;
          e_mem  = {r, data_wr, data_wstrb, data_addr, data_wdata};
          e_data = {r & mem_addr_ok, 1'b0, 32'h0};
        end else begin
          r      = inst_req;
          e_mem  = {r, 1'b0, 4'h0, inst_addr, 32'h0};
          e_inst = {r & mem_addr_ok, 1'b0, 32'h0};
        end
      end else begin
        if (m_owner == 1) e_data = {1'b0, mem_data_ok, mem_rdata};
        else              e_inst = {1'b0, mem_data_ok, mem_rdata};
      end
    end
  endfunction

  // Advance the model by one clock
  function automatic void model_step();
    int w;
    if (reset) begin
      m_owner = -1; m_addr_done = 1'b0; m_streak = 0;
    end else if (m_owner < 0) begin
      if (inst_req || data_req) begin
        if (inst_req && data_req) w = (m_streak == LIMIT) ? 0 : 1;
        else                      w = data_req ? 1 : 0;
        if (w == 1 && inst_req) m_streak = (m_streak < LIMIT) ? m_streak + 1 : LIMIT;
        else                    m_streak = 0;
        m_owner = w;
        m_addr_done = 1'b0;
      end
    end else if (!m_addr_done) begin
      if (!(m_owner == 1 ? data_req : inst_req)) m_owner = -1;
      else if (mem_addr_ok)                      m_addr_done = 1'b1;
    end else if (mem_data_ok) begin
      m_owner = -1;
      m_addr_done = 1'b0;
    end
  endfunction

  // Move to the negedge and compare every output against the model
  task automatic settle();
    #4;
    model_outputs();
    chk("mem_bus",   128'({mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata}), 128'(e_mem));
    chk("inst_side", 128'({inst_addr_ok, inst_data_ok, inst_rdata}), 128'(e_inst));
    chk("data_side", 128'({data_addr_ok, data_data_ok, data_rdata}), 128'(e_data));
  endtask

  task automatic advance();
    @(posedge clk);
    model_step();
    #1;
  endtask

  function automatic logic [127:0] all_outs();
    return 128'({inst_addr_ok, inst_data_ok, inst_rdata, data_addr_ok, data_data_ok,
                 data_rdata, mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata});
  endfunction

  task automatic mem_idle();
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = '0;
  endtask

  bit inst_taken = 1'b0;
  bit data_taken = 1'b0;

  initial begin
    reset = 1'b1;
    inst_req = 1'b0; inst_addr = '0;
    data_req = 1'b0; data_wr = 1'b0; data_wstrb = '0; data_addr = '0; data_wdata = '0;
    mem_idle();
    advance();
    settle(); chk("reset_outs", all_outs(), 128'(0));
    advance();
    reset = 1'b0;
    settle(); chk("post_reset_outs", all_outs(), 128'(0));
    advance();

    // Fetch only: address accepted at once, data one cycle later
    inst_req = 1'b1; inst_addr = 32'h1C00_0000;
    settle(); chk("t1_idle_req", 128'(mem_req), 128'(0));
    advance();
    mem_addr_ok = 1'b1;
    settle();
    chk("t1_mem_req", 128'(mem_req), 128'(1));
    chk("t1_addr", 128'(mem_addr), 128'(32'h1C00_0000));
    chk("t1_addr_ok", 128'(inst_addr_ok), 128'(1));
    advance();
    inst_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h0280_0C0C;
    settle();
    chk("t1_data_ok", 128'({inst_data_ok, inst_rdata}), 128'({1'b1, 32'h0280_0C0C}));
    chk("t1_mem_req_off", 128'(mem_req), 128'(0));
    chk("t1_data_quiet", 128'({data_addr_ok, data_data_ok, data_rdata}), 128'(0));
    advance();
    mem_idle();

    // Both request: the store wins, the fetch follows
    inst_req = 1'b1; inst_addr = 32'h1C00_0004;
    data_req = 1'b1; data_wr = 1'b1; data_wstrb = 4'hF;
    data_addr = 32'h0000_0100; data_wdata = 32'hDEAD_BEEF;
    settle(); advance();
    mem_addr_ok = 1'b1;
    settle();
    chk("t2_store_bus", 128'({mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata}),
        128'({1'b1, 1'b1, 4'hF, 32'h0000_0100, 32'hDEAD_BEEF}));
    chk("t2_grant", 128'({inst_addr_ok, data_addr_ok}), 128'(2'b01));
    advance();
    data_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1;
    settle(); chk("t2_store_done", 128'({inst_data_ok, data_data_ok}), 128'(2'b01));
    advance();
    mem_idle();
    settle(); advance();
    mem_addr_ok = 1'b1;
    settle();
    chk("t2_fetch_bus", 128'({mem_req, mem_wr, mem_wstrb, mem_addr}),
        128'({1'b1, 1'b0, 4'h0, 32'h1C00_0004}));
    advance();
    inst_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1;
    settle(); advance();
    mem_idle();

    // Starvation: four data grants, then the fetch, then data again
    inst_req = 1'b1; data_req = 1'b1; data_wr = 1'b0;
    for (int t = 0; t < 6; t++) begin
      mem_idle();
      settle(); advance();
      mem_addr_ok = 1'b1;
      settle();
      chk($sformatf("t3_grant%0d", t), 128'({inst_addr_ok, data_addr_ok}),
          128'((t == 4) ? 2'b10 : 2'b01));
      advance();
      mem_addr_ok = 1'b0; mem_data_ok = 1'b1;
      settle(); advance();
    end
    inst_req = 1'b0; data_req = 1'b0;
    mem_idle();
    settle(); advance();

    // Address stall: five cycles without addr_ok, then acceptance
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h0000_0200; data_wstrb = 4'h0;
    settle(); advance();
    for (int k = 0; k < 5; k++) begin
      settle();
      chk($sformatf("t4_stall%0d", k), 128'({mem_req, mem_addr, data_addr_ok}),
          128'({1'b1, 32'h0000_0200, 1'b0}));
      advance();
    end
    mem_addr_ok = 1'b1;
    settle(); chk("t4_accept", 128'(data_addr_ok), 128'(1));
    advance();
    data_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1;
    settle(); advance();
    mem_idle();

    // Flush: request dropped in ADDR, stray data_ok afterwards is ignored
    data_req = 1'b1;
    settle(); advance();
    data_req = 1'b0;
    settle(); chk("t5_flush_req", 128'(mem_req), 128'(0));
    advance();
    mem_data_ok = 1'b1; mem_rdata = 32'h1234_5678;
    settle();
    chk("t5_no_data_ok", 128'({mem_req, data_data_ok, inst_data_ok}), 128'(0));
    advance();
    mem_idle();

    // Reset while waiting for a response
    inst_req = 1'b1; inst_addr = 32'h1C00_0010;
    settle(); advance();
    mem_addr_ok = 1'b1;
    settle(); advance();
    inst_req = 1'b0; mem_addr_ok = 1'b0; reset = 1'b1;
    settle(); chk("t6_in_reset", all_outs(), 128'(0));
    advance();
    reset = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'hCAFE_F00D;
    settle(); chk("t6_after_reset", all_outs(), 128'(0));
    advance();
    mem_idle();

    // Randomized traffic, requests held until accepted or occasionally flushed
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 99) == 0);
      if (inst_req && !inst_taken) begin
        if ($urandom_range(0, 19) == 0) inst_req = 1'b0;
      end else begin
        inst_req  = 1'($urandom_range(0, 1));
        inst_addr = $urandom;
      end
      if (data_req && !data_taken) begin
        if ($urandom_range(0, 19) == 0) data_req = 1'b0;
      end else begin
        data_req   = 1'($urandom_range(0, 1));
        data_wr    = 1'($urandom_range(0, 1));
        data_wstrb = 4'($urandom);
        data_addr  = $urandom;
        data_wdata = $urandom;
      end
      mem_addr_ok = ($urandom_range(0, 2) != 0);
      mem_data_ok = ($urandom_range(0, 2) == 0);
      mem_rdata   = $urandom;
      settle();
      inst_taken = e_inst[33];
      data_taken = e_data[33];
      advance();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
